// File: rtl/rom_operand_mac_pkg.sv
// Shared definitions for rom_operand_mac: ROM word layout, op codes and FSM states.
package rom_operand_mac_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned FLD_W  = 12;

    // Field bit positions inside a packed ROM word
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 24;
    localparam int unsigned A_MSB  = 23;
    localparam int unsigned A_LSB  = 12;
    localparam int unsigned B_MSB  = 11;
    localparam int unsigned B_LSB  = 0;

    localparam logic [OP_W-1:0] OP_MAC  = 8'h00;
    localparam logic [OP_W-1:0] OP_MSUB = 8'h01;
    localparam logic [OP_W-1:0] OP_CLR  = 8'h02;

    // ROM word payload, MSB first: op, a, b
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [FLD_W-1:0] a;
        logic [FLD_W-1:0] b;
    } rom_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MUL,
        ST_EMIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    // True for ops that produce a product
    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MAC) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/rom_operand_mac_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// The start edge already folds in bit 0, so the product is final OPW cycles after start
// (done pulses then). Requires OPW >= 2.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored while busy)
//   a, b       : unsigned operands (multiplicand, multiplier)
//   busy       : iterations in progress
//   done       : one-cycle pulse, product valid
//   product    : unsigned a*b, registered
module shift_add_mul #(
    parameter int unsigned OPW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [2*OPW-1:0] product
);

    localparam int unsigned PW   = 2 * OPW;
    localparam int unsigned CNTW = $clog2(OPW + 1);

    logic [PW-1:0]   mcand;
    logic [OPW-1:0]  mplier;
    logic [CNTW-1:0] remain;
    logic [PW-1:0]   a_ext;

    assign a_ext = PW'(a);

    // Partial-product accumulation; product register doubles as the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            remain  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                product <= b[0] ? a_ext : '0;
                mcand   <= a_ext << 1;
                mplier  <= b >> 1;
                remain  <= CNTW'(OPW - 1);
                busy    <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                remain <= remain - CNTW'(1);
                if (remain == CNTW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rom_operand_mac.sv
// Walks WORD_COUNT ROM words, multiplies each word's operands, streams the products
// and keeps a wrap-around accumulator. Sole driver of the ROM advance enable.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a run (sampled in IDLE only)
//   rom_data   : current ROM word {op[31:24], a[23:12], b[11:0]}
//   rom_enable : one-cycle ROM advance pulse (NEXT state)
//   busy       : high outside IDLE
//   done       : one-cycle end-of-run pulse
//   prod_valid, prod_ready, prod_data : product stream
//   acc        : running accumulator, modulo 2^ACCW
module rom_operand_mac
    import rom_operand_mac_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 100,
    parameter int unsigned OPW        = 12,
    parameter int unsigned ACCW       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       rom_data,
    output logic              rom_enable,
    output logic              busy,
    output logic              done,
    output logic              prod_valid,
    input  logic              prod_ready,
    output logic [2*OPW-1:0]  prod_data,
    output logic [ACCW-1:0]   acc
);

    localparam int unsigned PW   = 2 * OPW;
    localparam int unsigned CNTW = $clog2(WORD_COUNT + 1);

    state_t          state;
    state_t          state_d;
    rom_word_t       word;
    logic [OP_W-1:0] op_q;
    logic [CNTW-1:0] word_cnt;

    logic            mul_start_c;
    logic            mul_busy;
    logic            mul_done;
    logic [PW-1:0]   mul_product;
    logic            handshake_c;
    logic            last_word_c;

    logic            rom_enable_d;
    logic            busy_d;
    logic            done_d;
    logic            prod_valid_d;

    assign word        = rom_word_t'(rom_data);
    assign mul_start_c = (state == ST_FETCH) && is_mul_op(word.op) && !mul_busy;
    assign handshake_c = (state == ST_EMIT) && prod_ready;
    assign last_word_c = (word_cnt == CNTW'(WORD_COUNT - 1));

    shift_add_mul #(
        .OPW (OPW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_c),
        .a       (OPW'(word.a)),
        .b       (OPW'(word.b)),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = is_mul_op(word.op) ? ST_MUL : ST_NEXT;
            ST_MUL:   if (mul_done) state_d = ST_EMIT;
            ST_EMIT:  if (prod_ready) state_d = ST_NEXT;
            ST_NEXT:  state_d = last_word_c ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the next state so the registered copies line up with state
    always_comb begin
        rom_enable_d = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        prod_valid_d = 1'b0;
        unique case (state_d)
            ST_IDLE: busy_d       = 1'b0;
            ST_EMIT: prod_valid_d = 1'b1;
            ST_NEXT: rom_enable_d = 1'b1;
            ST_DONE: done_d       = 1'b1;
            default: ;
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prod_valid <= 1'b0;
        end else begin
            rom_enable <= rom_enable_d;
            busy       <= busy_d;
            done       <= done_d;
            prod_valid <= prod_valid_d;
        end
    end

    // Datapath: op latch, word counter, product hold and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            word_cnt  <= '0;
            prod_data <= '0;
            acc       <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                word_cnt <= '0;
                acc      <= '0;
            end
            if (state == ST_FETCH) begin
                op_q <= word.op;
                if (word.op == OP_CLR) begin
                    acc <= '0;
                end
            end
            if ((state == ST_MUL) && mul_done) begin
                prod_data <= mul_product;
            end
            if (handshake_c) begin
                acc <= (op_q == OP_MSUB) ? acc - ACCW'(prod_data) : acc + ACCW'(prod_data);
            end
            if (state == ST_NEXT) begin
                word_cnt <= word_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_operand_mac.sv
module tb_rom_operand_mac;

    localparam int WC = 100;
    localparam int NV = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        prod_ready;
    logic [31:0] rom_data;
    logic        rom_enable;
    logic        busy;
    logic        done;
    logic        prod_valid;
    logic [23:0] prod_data;
    logic [31:0] acc;

    always #5 clk = ~clk;

    rom_operand_mac #(
        .WORD_COUNT (WC),
        .OPW        (12),
        .ACCW       (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_data   (rom_data),
        .rom_enable (rom_enable),
        .busy       (busy),
        .done       (done),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .acc        (acc)
    );

    // ROM model: address advances on enable and is never reset
    logic [31:0] rom_mem [0:2047];
    logic [10:0] rom_ptr = 11'd0;
    assign rom_data = rom_mem[rom_ptr];
    always @(posedge clk) if (rom_enable) rom_ptr <= rom_ptr + 11'd1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [23:0] prod;
        logic [31:0] acc_after;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] words [WC];
    logic [31:0] m_acc;
    int m_nprod;
    int m_base;

    int en_cnt, done_cnt, done_cyc, stall_cnt, prod_cnt;
    bit pend_acc = 0;
    logic [31:0] pend_val;
    bit prev_stall = 0;
    logic [23:0] prev_data;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the words with plain arithmetic; also loads them at the ROM pointer
    task automatic build_model();
        logic [31:0] run_acc;
        exp_q.delete();
        run_acc = 32'd0;
        m_nprod = 0;
        m_base  = 1;
        for (int i = 0; i < WC; i++) begin
            logic [7:0]  op;
            logic [23:0] p;
            exp_t        e;
            rom_mem[rom_ptr + 11'(i)] = words[i];
            op = words[i][31:24];
            p  = 24'(words[i][23:12]) * 24'(words[i][11:0]);
            if (op == 8'h00 || op == 8'h01) begin
                run_acc = (op == 8'h00) ? run_acc + 32'(p) : run_acc - 32'(p);
                e.prod = p;
                e.acc_after = run_acc;
                exp_q.push_back(e);
                m_nprod++;
                m_base += 15;
            end else begin
                if (op == 8'h02) run_acc = 32'd0;
                m_base += 2;
            end
        end
        m_acc = run_acc;
    endtask

    // Stream monitor, sampled on the falling edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (rom_enable) en_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pend_acc) begin
                check32("acc_after_handshake", acc, pend_val);
                pend_acc = 0;
            end
            if (prev_stall) begin
                check32("valid_held", 32'(prod_valid), 32'd1);
                check32("data_held", 32'(prod_data), 32'(prev_data));
            end
            prev_stall = prod_valid && !prod_ready;
            prev_data  = prod_data;
            if (prod_valid && !prod_ready) stall_cnt++;
            if (prod_valid && prod_ready) begin
                prod_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_product: got %h expected none", prod_data);
                end else begin
                    e = exp_q.pop_front();
                    check32("product", 32'(prod_data), 32'(e.prod));
                    pend_acc = 1;
                    pend_val = e.acc_after;
                end
            end
        end
    end

    // mode 0: ready high, 1: random ready, 2: ready low for 7 EMIT cycles on the first product
    task automatic do_run(input string name, input int mode, input bit poke, input bit has_exp,
                          input logic [31:0] t_acc, input int t_nprod, input int t_cycles);
        int s0;
        int hold_n;
        bit fin;
        logic [23:0] hd;
        logic [31:0] ha;
        build_model();
        en_cnt = 0; done_cnt = 0; stall_cnt = 0; prod_cnt = 0; hold_n = 0;
        prod_ready = (mode == 2) ? 1'b0 : 1'b1;
        start = 1'b1;
        s0 = cyc;
        tick();
        start = 1'b0;
        fin = 0;
        for (int i = 0; i < 6000 && !fin; i++) begin
            tick();
            if (poke && i == 20) start = 1'b1;
            if (poke && i == 21) start = 1'b0;
            if (mode == 1) prod_ready = 1'($urandom_range(0, 1));
            if (mode == 2 && prod_valid && !prod_ready) begin
                if (hold_n == 0) begin
                    hd = prod_data;
                    ha = acc;
                end else begin
                    check32({name, "_stall_data"}, 32'(prod_data), 32'(hd));
                    check32({name, "_stall_acc"}, acc, ha);
                end
                hold_n++;
                if (hold_n == 8) prod_ready = 1'b1;
            end
            if (done_cnt > 0) fin = 1;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within budget", name);
        end
        prod_ready = 1'b1;
        repeat (4) tick();
        check32({name, "_acc_model"}, acc, m_acc);
        check32({name, "_nprod_model"}, 32'(prod_cnt), 32'(m_nprod));
        check32({name, "_enables"}, 32'(en_cnt), 32'(WC));
        check32({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check32({name, "_cycles_model"}, 32'(done_cyc - s0), 32'(m_base + stall_cnt));
        check32({name, "_busy_after"}, 32'(busy), 32'd0);
        check32({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        if (has_exp) begin
            check32({name, "_acc"}, acc, t_acc);
            check32({name, "_nprod"}, 32'(prod_cnt), 32'(t_nprod));
            check32({name, "_cycles"}, 32'(done_cyc - s0), 32'(t_cycles));
        end
    endtask

    typedef struct {
        logic [31:0] w0, w1, w2, fill;
        int          mode;
        bit          poke;
        logic [31:0] exp_acc;
        int          exp_nprod;
        int          exp_cycles;
    } vec_t;

    vec_t  vecs [NV];
    string names [NV];

    initial begin
        names[0] = "mac_all";   vecs[0] = '{32'h00100100, 32'h00100100, 32'h00100100, 32'h00100100, 0, 1'b0, 32'h00640000, 100, 1501};
        names[1] = "mac_msub";  vecs[1] = '{32'h00003005, 32'h01003005, 32'h7F000000, 32'h7F000000, 0, 1'b1, 32'h00000000, 2, 227};
        names[2] = "msub_wrap"; vecs[2] = '{32'h01003005, 32'h01003005, 32'h7F000000, 32'h7F000000, 0, 1'b0, 32'hFFFFFFE2, 2, 227};
        names[3] = "mac_clr";   vecs[3] = '{32'h00002003, 32'h02000000, 32'h7F000000, 32'h7F000000, 0, 1'b0, 32'h00000000, 1, 214};
        names[4] = "stall7";    vecs[4] = '{32'h00002003, 32'h7F000000, 32'h7F000000, 32'h7F000000, 2, 1'b0, 32'h00000006, 1, 221};
        names[5] = "max_ops";   vecs[5] = '{32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 0, 1'b0, 32'h63F38064, 100, 1501};

        rst_n = 1'b0;
        start = 1'b0;
        prod_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_rom_enable", 32'(rom_enable), 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_prod_valid", 32'(prod_valid), 32'd0);
        check32("rst_prod_data", 32'(prod_data), 32'd0);
        check32("rst_acc", acc, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < NV; t++) begin
            words[0] = vecs[t].w0;
            words[1] = vecs[t].w1;
            words[2] = vecs[t].w2;
            for (int i = 3; i < WC; i++) words[i] = vecs[t].fill;
            do_run(names[t], vecs[t].mode, vecs[t].poke, 1'b1,
                   vecs[t].exp_acc, vecs[t].exp_nprod, vecs[t].exp_cycles);
        end

        // Reset in the middle of the second word's multiply
        for (int i = 0; i < WC; i++) words[i] = 32'h00100100;
        build_model();
        prod_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check32("pre_abort_busy", 32'(busy), 32'd1);
        check32("pre_abort_acc", acc, 32'h00010000);
        #2;
        rst_n = 1'b0;
        #1;
        check32("abort_rom_enable", 32'(rom_enable), 32'd0);
        check32("abort_busy", 32'(busy), 32'd0);
        check32("abort_done", 32'(done), 32'd0);
        check32("abort_prod_valid", 32'(prod_valid), 32'd0);
        check32("abort_prod_data", 32'(prod_data), 32'd0);
        check32("abort_acc", acc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("abort_hold_enable", 32'(rom_enable), 32'd0);
            check32("abort_hold_busy", 32'(busy), 32'd0);
        end
        exp_q.delete();
        pend_acc = 0;
        prev_stall = 0;
        rst_n = 1'b1;
        tick();
        words[0] = 32'h00003005;
        words[1] = 32'h00002003;
        for (int i = 2; i < WC; i++) words[i] = 32'h7F000000;
        do_run("after_reset", 0, 1'b0, 1'b1, 32'h00000015, 2, 227);

        // Random words and random back-pressure against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < WC; i++) begin
                int unsigned sel;
                logic [7:0] op;
                sel = $urandom_range(0, 9);
                if (sel < 4) op = 8'h00;
                else if (sel < 7) op = 8'h01;
                else if (sel == 7) op = 8'h02;
                else op = 8'($urandom_range(3, 255));
                words[i] = {op, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
            end
            do_run("random", 1, 1'b0, 1'b0, 32'd0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_operand_mac.md
# rom_operand_mac

Downstream consumer of the instruction/operand ROM. Walks a run of packed 32-bit ROM words by pulsing the ROM's advance enable, decodes each word into an opcode and two 12-bit operands, and multiplies them with an iterative shift-add unit. Each product goes out on a valid/ready stream and is folded into a running accumulator. The block sits between the ROM and the result sink, and is the only driver of the ROM's `enable`.

## Interface
Parameters:
- `WORD_COUNT`, 100: ROM words consumed per run (1..256).
- `OPW`, 12: operand width.
- `ACCW`, 32: accumulator width (≥ 2*OPW).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `rom_data` in 32: current ROM word, combinational from the ROM.
- `rom_enable` out 1: one-cycle pulse that advances the ROM address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `prod_valid` out 1: product available.
- `prod_ready` in 1: sink accepts the product.
- `prod_data` out 2*OPW: unsigned product a*b.
- `acc` out ACCW: running accumulator.

## Operation
- Word format:
  - [31:24] op.
  - [23:12] a.
  - [11:0] b.
- Op codes:
  - 0x00 MAC: acc += a*b.
  - 0x01 MSUB: acc -= a*b.
  - 0x02 CLR: acc = 0, no product is emitted.
  - Any other value is a NOP: no product, still counted.
- States: IDLE, FETCH, MUL, EMIT, NEXT, DONE.
- IDLE: on `start`, clear the word counter and `acc`, go to FETCH.
- FETCH: latch op, a and b from `rom_data`.
  - MAC/MSUB go to MUL.
  - CLR zeroes `acc` and goes to NEXT.
  - NOP goes to NEXT.
- MUL: OPW iterations of an unsigned shift-add, one multiplier bit per cycle, LSB first, then go to EMIT.
- EMIT: hold `prod_valid` high with `prod_data` stable until `prod_ready`.
  - On the handshake cycle, update `acc` per op and go to NEXT.
- NEXT: assert `rom_enable` for exactly this cycle and increment the counter.
  - If the counter reaches WORD_COUNT, go to DONE; otherwise go to FETCH.
- DONE: assert `done` for one cycle, then return to IDLE.
- Accumulator arithmetic is modulo 2^ACCW, with wrap-around and no saturation. The product is zero-extended before the add or subtract.
- `start` is ignored while `busy` is high.
- The ROM address is never rewound. Each run issues exactly WORD_COUNT `rom_enable` pulses and continues from wherever the ROM currently points.

## Timing
- Reset values: state IDLE, `rom_enable` 0, `busy` 0, `done` 0, `prod_valid` 0, `prod_data` 0, `acc` 0, counter 0.
- `start` high in IDLE gives FETCH on the next cycle.
- MAC/MSUB word with `prod_ready` held high: 1 (FETCH) + OPW (MUL) + 1 (EMIT) + 1 (NEXT) = 15 cycles.
- CLR or NOP word: 2 cycles (FETCH, NEXT).
- Each `prod_ready` low cycle in EMIT adds one cycle.
- `acc` reflects the new value the cycle after the EMIT handshake.
- `rom_data` is sampled only in FETCH. The updated ROM word is valid in the FETCH that follows NEXT, because the ROM updates its address on the edge ending NEXT.
- `prod_valid` must not drop before the handshake. `prod_data` is registered.
- Asserting `rst_n` low in any state forces the reset values immediately.
  - No partial `rom_enable` pulse is left asserted.
  - The ROM's address is not reset by this block.

## Structure
- Shared package holds:
  - Field bit positions for op, a and b.
  - Op-code constants OP_MAC, OP_MSUB, OP_CLR.
  - The state enum.
- One sub-module, `shift_add_mul`: OPW×OPW iterative multiplier.
  - Ports: start, a, b, busy, done, product.
  - Latency is OPW cycles.
  - Instantiated once, driven by the MUL state.

## Test plan
- All words 32'h00100100, WORD_COUNT=100, `prod_ready`=1:
  - 100 products of 0x10000.
  - Final `acc` = 0x00640000.
  - Exactly 100 `rom_enable` pulses.
  - One `done`, 100×15+1 cycles after `start`.
- Words 0x00003005 then 0x01003005, WORD_COUNT=2: products 15 and 15, final `acc` = 0.
  - Second variant with words 0x01003005, 0x01003005: final `acc` = 0xFFFFFFE2 (wrap-around).
- Words MAC 0x00002003, CLR 0x02000000, NOP 0x7F000000:
  - Exactly one product (6).
  - `acc` is 6, then 0 after CLR.
  - 3 enable pulses.
- `prod_ready` low for 7 cycles during EMIT:
  - `prod_valid` and `prod_data` held stable.
  - `acc` unchanged until the handshake.
  - The word takes 22 cycles.
- `rst_n` low mid-MUL:
  - All outputs return to reset values asynchronously.
  - No `rom_enable`.
  - A subsequent `start` runs normally.
- `start` pulsed while `busy`: no effect, run length and `done` timing unchanged.
